// File: rtl/image_frame_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module : image_pkg
// Brief  : Shared types and sizing helpers for the frame-capture block.
// Rev    : 1.0  initial release
// ============================================================================
package image_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int PIX_W  = 8;
    localparam int TRIP_W = 9 * PIX_W;

    function automatic int words_per_row(input int width);
        return width / 3;
    endfunction

    function automatic int frame_words(input int width, input int height);
        return (width / 3) * height;
    endfunction

endpackage
`default_nettype wire

// File: rtl/image_frame_capture_if.sv
`default_nettype none
// ============================================================================
// Module : image_frame_capture_if
// Brief  : Video-in / memory-out bundle of the frame-capture block.
// Rev    : 1.0  initial release
// ============================================================================
interface image_frame_capture_if #(
    parameter int ADDR_W = 17
);
    import image_pkg::*;

    logic              Vsync;
    logic              Hsync;
    logic [PIX_W-1:0]  R0_in, G0_in, B0_in;
    logic [PIX_W-1:0]  R1_in, G1_in, B1_in;
    logic [PIX_W-1:0]  R2_in, G2_in, B2_in;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [TRIP_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              busy;
    logic              frame_done;
    logic              overflow;

    modport master (
        output Vsync, Hsync,
        output R0_in, G0_in, B0_in, R1_in, G1_in, B1_in, R2_in, G2_in, B2_in,
        output mem_ready,
        input  mem_we, mem_addr, mem_wdata, busy, frame_done, overflow
    );

    modport slave (
        input  Vsync, Hsync,
        input  R0_in, G0_in, B0_in, R1_in, G1_in, B1_in, R2_in, G2_in, B2_in,
        input  mem_ready,
        output mem_we, mem_addr, mem_wdata, busy, frame_done, overflow
    );

endinterface
`default_nettype wire

// File: rtl/image_frame_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module : pix_fifo
// Brief  : Synchronous FIFO with sync clear; head word visible combinationally.
// Rev    : 1.0  initial release
// ============================================================================
module pix_fifo #(
    parameter int WIDTH = 89,
    parameter int DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clear,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_last
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      w_level;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level = r_wptr - r_rptr;
    assign o_empty = (w_level == '0);
    assign o_full  = (w_level == (AW+1)'(DEPTH));
    assign o_last  = (w_level == (AW+1)'(1));
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/image_frame_capture.sv
`default_nettype none
// ============================================================================
// Module : image_frame_capture
// Brief  : Captures one 3-pixel/clock video frame into word memory, BMP bottom-up.
// Rev    : 1.0  initial release
// ============================================================================
module image_frame_capture
    import image_pkg::*;
#(
    parameter int Im_width   = 768,
    parameter int Im_height  = 512,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 17
) (
    input  wire logic             clk,
    input  wire logic             Reset,
    image_frame_capture_if.slave  bus
);
    localparam int WPR     = words_per_row(Im_width);
    localparam int ENTRY_W = ADDR_W + TRIP_W;

    localparam logic [ADDR_W-1:0] c_WPR           = ADDR_W'(WPR);
    localparam logic [ADDR_W-1:0] c_LAST_ROW_BASE = ADDR_W'((Im_height - 1) * WPR);
    localparam logic [ADDR_W:0]   c_FRAME_WORDS   = (ADDR_W+1)'(frame_words(Im_width, Im_height));

    state_t            r_state;
    logic              r_vsync_d;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_wcol;
    logic [ADDR_W:0]   r_count;

    logic              w_vsync_rise, w_restart, w_capture;
    logic              w_push, w_pop, w_drop, w_flush_end;
    logic              w_full, w_empty, w_last;
    logic [ADDR_W:0]   w_count_next;
    logic [ADDR_W-1:0] w_addr;
    logic [TRIP_W-1:0] w_trip;
    logic [ENTRY_W-1:0] w_head;

    assign w_vsync_rise = bus.Vsync && !r_vsync_d;
    // A frame start re-arms from any state except DONE, which always returns to IDLE.
    assign w_restart    = w_vsync_rise && (r_state != ST_DONE);
    assign w_capture    = bus.Hsync && !w_restart &&
                          (r_state == ST_ARMED || r_state == ST_CAPTURE);
    assign w_pop        = bus.mem_ready && !w_empty;
    assign w_push       = w_capture && (!w_full || w_pop);
    assign w_drop       = w_capture && w_full && !w_pop;
    assign w_flush_end  = (r_state == ST_FLUSH) && (w_pop ? w_last : w_empty);
    assign w_count_next = r_count + 1'b1;

    // Row base tracks (Im_height-1-row)*WPR so no multiplier is needed.
    assign w_addr = r_row_base + r_wcol;
    assign w_trip = {bus.B2_in, bus.G2_in, bus.R2_in,
                     bus.B1_in, bus.G1_in, bus.R1_in,
                     bus.B0_in, bus.G0_in, bus.R0_in};

    pix_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (Reset),
        .i_clear (w_restart),
        .i_push  (w_push),
        .i_wdata ({w_addr, w_trip}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_vsync_d  <= 1'b0;
            r_overflow <= 1'b0;
            r_row_base <= c_LAST_ROW_BASE;
            r_wcol     <= '0;
            r_count    <= '0;
        end else begin
            r_vsync_d <= bus.Vsync;
            if (w_restart) begin
                r_state    <= ST_ARMED;
                r_overflow <= 1'b0;
                r_row_base <= c_LAST_ROW_BASE;
                r_wcol     <= '0;
                r_count    <= '0;
            end else begin
                // Dropped triplets still advance position so later addresses stay correct.
                if (w_capture) begin
                    r_count <= w_count_next;
                    if (r_wcol == c_WPR - 1'b1) begin
                        r_wcol     <= '0;
                        r_row_base <= r_row_base - c_WPR;
                    end else begin
                        r_wcol <= r_wcol + 1'b1;
                    end
                    if (w_drop) r_overflow <= 1'b1;
                end
                case (r_state)
                    ST_ARMED, ST_CAPTURE: begin
                        if (w_capture)
                            r_state <= (w_count_next == c_FRAME_WORDS) ? ST_FLUSH : ST_CAPTURE;
                    end
                    ST_FLUSH: begin
                        if (w_flush_end) r_state <= ST_DONE;
                    end
                    ST_DONE:  r_state <= ST_IDLE;
                    default:  r_state <= r_state;
                endcase
            end
        end
    end

    assign bus.mem_we     = !w_empty;
    assign bus.mem_addr   = w_empty ? '0 : w_head[ENTRY_W-1 -: ADDR_W];
    assign bus.mem_wdata  = w_empty ? '0 : w_head[TRIP_W-1:0];
    assign bus.busy       = (r_state == ST_ARMED) || (r_state == ST_CAPTURE) ||
                            (r_state == ST_FLUSH);
    assign bus.frame_done = w_flush_end && !w_restart;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_image_frame_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_image_frame_capture
// Brief  : Directed bench: 6x2 frame (depth 8) and 6x4 frame (depth 4) instances.
// Rev    : 1.0  initial release
// ============================================================================
module tb_image_frame_capture;

    logic clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;
    int   fd_cnt;

    always #5 clk = ~clk;

    image_frame_capture_if #(.ADDR_W(8)) ifa ();
    image_frame_capture_if #(.ADDR_W(8)) ifb ();

    image_frame_capture #(.Im_width(6), .Im_height(2), .FIFO_DEPTH(8), .ADDR_W(8))
        u_a (.clk(clk), .Reset(Reset), .bus(ifa));
    image_frame_capture #(.Im_width(6), .Im_height(4), .FIFO_DEPTH(4), .ADDR_W(8))
        u_b (.clk(clk), .Reset(Reset), .bus(ifb));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte k of a triplet stream word is base+k+1; bytes ordered R0,G0,B0,R1,... from LSB.
    function automatic logic [71:0] exp_word(input logic [7:0] b);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[8*k +: 8] = b + 8'(k + 1);
        return w;
    endfunction

    task automatic set_pix(input logic [7:0] b);
        ifa.R0_in = b + 8'd1; ifa.G0_in = b + 8'd2; ifa.B0_in = b + 8'd3;
        ifa.R1_in = b + 8'd4; ifa.G1_in = b + 8'd5; ifa.B1_in = b + 8'd6;
        ifa.R2_in = b + 8'd7; ifa.G2_in = b + 8'd8; ifa.B2_in = b + 8'd9;
        ifb.R0_in = b + 8'd1; ifb.G0_in = b + 8'd2; ifb.B0_in = b + 8'd3;
        ifb.R1_in = b + 8'd4; ifb.G1_in = b + 8'd5; ifb.B1_in = b + 8'd6;
        ifb.R2_in = b + 8'd7; ifb.G2_in = b + 8'd8; ifb.B2_in = b + 8'd9;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] addr_q [4];
        logic [7:0] base_q [4];

        Reset = 1'b0;
        ifa.Vsync = 0; ifa.Hsync = 0; ifa.mem_ready = 0;
        ifb.Vsync = 0; ifb.Hsync = 0; ifb.mem_ready = 0;
        set_pix(8'h00);
        tick(); tick();
        Reset = 1'b1;
        tick();

        // Reset state
        chk("rst_we",    ifa.mem_we, 0);
        chk("rst_addr",  ifa.mem_addr, 0);
        chk("rst_wdata", ifa.mem_wdata, 0);
        chk("rst_busy",  ifa.busy, 0);
        chk("rst_done",  ifa.frame_done, 0);
        chk("rst_ovf",   ifa.overflow, 0);

        // Basic 6x2 frame, memory always ready: addresses 2,3,0,1
        ifa.mem_ready = 1; ifa.Vsync = 1;
        tick();
        chk("a_armed_busy", ifa.busy, 1);
        chk("a_armed_we",   ifa.mem_we, 0);
        ifa.Vsync = 0; ifa.Hsync = 1;
        set_pix(8'h00); tick();
        chk("a_t0_we",    ifa.mem_we, 1);
        chk("a_t0_addr",  ifa.mem_addr, 2);
        chk("a_t0_wdata", ifa.mem_wdata, 72'h090807060504030201);
        set_pix(8'h10); tick();
        chk("a_t1_addr",  ifa.mem_addr, 3);
        chk("a_t1_wdata", ifa.mem_wdata, exp_word(8'h10));
        chk("a_t1_done",  ifa.frame_done, 0);
        set_pix(8'h20); tick();
        chk("a_t2_addr",  ifa.mem_addr, 0);
        set_pix(8'h30); tick();
        chk("a_t3_addr",  ifa.mem_addr, 1);
        chk("a_t3_wdata", ifa.mem_wdata, exp_word(8'h30));
        chk("a_t3_done",  ifa.frame_done, 1);
        ifa.Hsync = 0;
        tick();
        chk("a_done_pulse", ifa.frame_done, 0);
        chk("a_done_we",    ifa.mem_we, 0);
        chk("a_done_busy",  ifa.busy, 0);
        tick();

        // Overflow on 6x4 frame, depth 4, memory stalled: 4 stored, 2 dropped
        ifb.mem_ready = 0; ifb.Vsync = 1;
        tick();
        ifb.Vsync = 0; ifb.Hsync = 1;
        for (int k = 0; k < 6; k++) begin
            set_pix(8'h40 + 8'(16 * k));
            tick();
            if (k == 3) begin
                chk("b_full_ovf",  ifb.overflow, 0);
                chk("b_full_addr", ifb.mem_addr, 6);
            end
            if (k == 4) chk("b_drop5_ovf", ifb.overflow, 1);
        end
        chk("b_drop6_ovf",  ifb.overflow, 1);
        chk("b_drop6_addr", ifb.mem_addr, 6);
        ifb.Hsync = 0; ifb.mem_ready = 1;
        addr_q = '{8'd6, 8'd7, 8'd4, 8'd5};
        for (int i = 0; i < 4; i++) begin
            chk("b_drain_we",    ifb.mem_we, 1);
            chk("b_drain_addr",  ifb.mem_addr, addr_q[i]);
            chk("b_drain_wdata", ifb.mem_wdata, exp_word(8'h40 + 8'(16 * i)));
            tick();
        end
        chk("b_drain_empty", ifb.mem_we, 0);
        // Triplets 5 and 6 (addrs 2,3) were dropped; triplet 7 lands at addr 0
        ifb.Hsync = 1;
        set_pix(8'hA0); tick();
        chk("b_t7_addr", ifb.mem_addr, 0);
        set_pix(8'hB0); tick();
        chk("b_t8_addr", ifb.mem_addr, 1);
        chk("b_t8_done", ifb.frame_done, 1);
        ifb.Hsync = 0;
        tick();
        chk("b_done_pulse", ifb.frame_done, 0);
        chk("b_ovf_sticky", ifb.overflow, 1);
        tick();

        // Full FIFO with simultaneous push and pop
        ifb.mem_ready = 0; ifb.Vsync = 1;
        tick();
        chk("b_f2_ovf_clr", ifb.overflow, 0);
        chk("b_f2_busy",    ifb.busy, 1);
        ifb.Vsync = 0; ifb.Hsync = 1;
        for (int k = 0; k < 4; k++) begin
            set_pix(8'h10 * 8'(k + 1));
            tick();
        end
        ifb.mem_ready = 1;
        set_pix(8'h80); tick();
        chk("b_pp_ovf",  ifb.overflow, 0);
        chk("b_pp_addr", ifb.mem_addr, 7);
        ifb.Hsync = 0;
        addr_q = '{8'd7, 8'd4, 8'd5, 8'd2};
        base_q = '{8'h20, 8'h30, 8'h40, 8'h80};
        for (int i = 0; i < 4; i++) begin
            chk("b_pp_drain_addr",  ifb.mem_addr, addr_q[i]);
            chk("b_pp_drain_wdata", ifb.mem_wdata, exp_word(base_q[i]));
            tick();
        end
        chk("b_pp_empty", ifb.mem_we, 0);

        // Abort after 2 of 4 triplets, then a clean frame
        ifa.mem_ready = 0; ifa.Vsync = 1;
        tick();
        ifa.Vsync = 0; ifa.Hsync = 1;
        set_pix(8'h00); tick();
        set_pix(8'h10); tick();
        chk("a_ab_pre_we", ifa.mem_we, 1);
        ifa.Hsync = 0; ifa.Vsync = 1;
        tick();
        chk("a_ab_we",   ifa.mem_we, 0);
        chk("a_ab_busy", ifa.busy, 1);
        chk("a_ab_done", ifa.frame_done, 0);
        ifa.Vsync = 0; ifa.mem_ready = 1; ifa.Hsync = 1;
        fd_cnt = 0;
        addr_q = '{8'd2, 8'd3, 8'd0, 8'd1};
        for (int i = 0; i < 4; i++) begin
            set_pix(8'h50 + 8'(16 * i));
            tick();
            chk("a_re_addr", ifa.mem_addr, addr_q[i]);
            if (ifa.frame_done === 1'b1) fd_cnt++;
        end
        ifa.Hsync = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ifa.frame_done === 1'b1) fd_cnt++;
        end
        chk("a_re_done_cnt", fd_cnt, 1);
        chk("a_re_idle",     ifa.busy, 0);

        // Asynchronous reset in the middle of a capture
        ifb.mem_ready = 0; ifb.Hsync = 1;
        set_pix(8'hC0); tick();
        chk("b_mid_we",   ifb.mem_we, 1);
        chk("b_mid_addr", ifb.mem_addr, 3);
        ifb.Hsync = 0;
        #2;
        Reset = 1'b0;
        #1;
        chk("b_ar_we",    ifb.mem_we, 0);
        chk("b_ar_addr",  ifb.mem_addr, 0);
        chk("b_ar_wdata", ifb.mem_wdata, 0);
        chk("b_ar_busy",  ifb.busy, 0);
        chk("b_ar_ovf",   ifb.overflow, 0);
        tick();
        Reset = 1'b1;
        ifb.Hsync = 1;
        tick();
        chk("b_idle_hsync_we", ifb.mem_we, 0);
        chk("b_idle_busy",     ifb.busy, 0);
        ifb.Hsync = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
